ls_sequencer: RTL and testbench
===============================

Name: ls_sequencer

Overview:
- Controller that sequences the 64-bit load/store datapath (register bank + adder + RAM).
- Accepts one packed 32-bit load/store instruction at a time over a valid/ready handshake and decodes it.
- Drives the datapath control inputs (enable, ra, rb, rw, dataIn, load_store) across a fixed multi-cycle schedule.
- Reports completion with a one-cycle done pulse and maintains a retired-instruction counter.

Parameters:
BITS, 63, MSB index of datapath words (datapath width = BITS+1)
MEM_LAT, 1, cycles the effective address is held stable before the load write-back cycle (1..15)
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
instr  input  32  packed instruction: [31] op (1=load, 0=store), [30:26] rw, [25:21] ra, [20:16] rb, [15:0] imm (signed)
instr_valid  input  1  instr is valid this cycle
instr_ready  output  1  sequencer can accept an instruction
dp_enable  output  1  to datapath enable
dp_load_store  output  1  to datapath load_store (1=load, 0=store)
dp_ra  output  5  to datapath ra
dp_rb  output  5  to datapath rb
dp_rw  output  5  to datapath rw
dp_dataIn  output  BITS+1  to datapath dataIn: imm sign-extended to BITS+1
busy  output  1  instruction in flight
done  output  1  one-cycle pulse when an instruction retires
retired  output  CNT_W  count of retired instructions

Behaviour:
- Reset (asynchronous, immediate): state=IDLE.
- Reset values: instr_ready=1, busy=0, done=0, dp_enable=0, dp_load_store=0, dp_ra/rb/rw=0, dp_dataIn=0, retired=0.
- Reset asserted mid-instruction aborts it: no further dp_enable pulse, no done, retired not incremented.
- Acceptance: an instruction is accepted on a rising edge where instr_valid=1 in IDLE. instr_ready=1 only in IDLE.
- On acceptance, fields are registered. dp_* outputs hold the registered fields, stable until the next acceptance; between instructions they are not reset to 0.
- Sign extension: dp_dataIn = {{(BITS-15){imm[15]}}, imm}.
- FSM states: IDLE, ADDR, WRITE, DONE.
  - IDLE: instr_ready=1. On accept -> ADDR. busy rises in the cycle after acceptance.
  - ADDR: dp_enable=0, busy=1. Stays MEM_LAT cycles (internal down-counter loaded with MEM_LAT-1 on entry) so the adder output and RAM read settle -> WRITE.
  - WRITE: dp_enable=1 for exactly one cycle.
    - Load: the register bank writes mem_read into rw at this edge.
    - Store: the RAM writes regA at address dataIn+regB+1 at this edge.
    - -> DONE.
  - DONE: done=1 for one cycle, busy=0, retired increments (wraps modulo 2^CNT_W) -> IDLE.
- Latency: acceptance edge to done pulse = MEM_LAT+2 cycles. Back-to-back throughput: one instruction per MEM_LAT+3 cycles; the next acceptance can occur on the edge ending DONE+1 (first IDLE cycle).
- instr_valid while not in IDLE is ignored (not queued); the requester must hold valid until ready.
- instr changes while in flight: no effect (fields already latched).
- Load with rw=0 is executed normally; no register is treated as hard-wired zero.
- dp_enable is never high outside WRITE; it is never high for two consecutive cycles.

Test Plan:
- Reset mid-flight: accept a load, assert reset during ADDR -> dp_enable stays 0, done never pulses, retired=0, instr_ready=1 immediately.
- Store: MEM_LAT=1, instr={0,rw=0,ra=3,rb=4,imm=0x0010} with r3=0xDEAD, r4=0x100 -> dp_enable high exactly 1 cycle at cycle 2 after acceptance with dp_load_store=0; RAM[0x111]=0xDEAD; done at cycle 3; retired=1.
- Load back: instr={1,rw=7,ra=0,rb=4,imm=0x0010} -> r7=0xDEAD after WRITE; dataOutA with ra=7 reads 0xDEAD; retired=2.
- Negative immediate: imm=0xFFFF -> dp_dataIn=64'hFFFF_FFFF_FFFF_FFFF; store with rb=r4=0x100 writes RAM[0x100].
- Handshake: hold instr_valid=1 continuously with 3 instructions, MEM_LAT=3 -> acceptances spaced exactly 6 cycles apart; instr_ready low during ADDR/WRITE/DONE; 3 done pulses; retired=3.
- Counter wrap: CNT_W=2, run 5 instructions -> retired sequence 1,2,3,0,1.

Source files
------------

// File: rtl/ls_sequencer.sv
// ls_sequencer
//   Control sequencer for the 64-bit load/store datapath (register bank,
//   address adder, RAM). It takes one packed instruction at a time over a
//   valid/ready handshake, latches its fields and walks the datapath through
//   a fixed IDLE -> ADDR -> WRITE -> DONE schedule. All outputs are flops.
//
// Parameters
//   BITS     MSB index of datapath words (datapath width = BITS+1)
//   MEM_LAT  cycles the effective address is held before write-back (1..15)
//   CNT_W    width of the retired-instruction counter
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   instr          [31] op (1=load), [30:26] rw, [25:21] ra, [20:16] rb,
//                  [15:0] signed immediate
//   instr_valid    instr is valid this cycle
//   instr_ready    sequencer is idle and can accept an instruction
//   dp_enable      one-cycle datapath write strobe (WRITE state only)
//   dp_load_store  1=load, 0=store
//   dp_ra/rb/rw    register addresses to the datapath
//   dp_dataIn      sign-extended immediate
//   busy           instruction in flight (ADDR or WRITE)
//   done           one-cycle retirement pulse
//   retired        retired-instruction count, wraps modulo 2^CNT_W
module ls_sequencer #(
    parameter int BITS    = 63,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic             dp_enable,
    output logic             dp_load_store,
    output logic [4:0]       dp_ra,
    output logic [4:0]       dp_rb,
    output logic [4:0]       dp_rw,
    output logic [BITS:0]    dp_dataIn,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ADDR dwell counter reload: counting down to zero gives MEM_LAT cycles
    localparam logic [3:0] LAT_RELOAD = 4'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q,  state_d;
    logic [3:0]       lat_cnt_q, lat_cnt_d;
    logic             accept_s;

    logic             instr_ready_q,   instr_ready_d;
    logic             dp_enable_q,     dp_enable_d;
    logic             dp_load_store_q, dp_load_store_d;
    logic [4:0]       dp_ra_q,         dp_ra_d;
    logic [4:0]       dp_rb_q,         dp_rb_d;
    logic [4:0]       dp_rw_q,         dp_rw_d;
    logic [BITS:0]    dp_data_in_q,    dp_data_in_d;
    logic             busy_q,          busy_d;
    logic             done_q,          done_d;
    logic [CNT_W-1:0] retired_q,       retired_d;

    assign accept_s = (state_q == S_IDLE) && instr_valid;

    // State register and ADDR dwell counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lat_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d   = S_ADDR;
                    lat_cnt_d = LAT_RELOAD;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_ADDR: begin
                if (lat_cnt_q == 4'd0) begin
                    state_d = S_WRITE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: decoded from the next state so every output is a flop
    // that changes on the same edge as the state it belongs to.
    always_comb begin
        instr_ready_d = (state_d == S_IDLE);
        busy_d        = (state_d == S_ADDR) || (state_d == S_WRITE);
        dp_enable_d   = (state_d == S_WRITE);
        done_d        = (state_d == S_DONE);
        // DONE is entered only from WRITE, so this counts once per instruction
        if (state_d == S_DONE) begin
            retired_d = retired_q + CNT_ONE;
        end else begin
            retired_d = retired_q;
        end
        // Fields stay put between instructions; only a new acceptance moves them
        if (accept_s) begin
            dp_load_store_d = instr[31];
            dp_rw_d         = instr[30:26];
            dp_ra_d         = instr[25:21];
            dp_rb_d         = instr[20:16];
            dp_data_in_d    = {{(BITS-15){instr[15]}}, instr[15:0]};
        end else begin
            dp_load_store_d = dp_load_store_q;
            dp_rw_d         = dp_rw_q;
            dp_ra_d         = dp_ra_q;
            dp_rb_d         = dp_rb_q;
            dp_data_in_d    = dp_data_in_q;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_ready_q   <= 1'b1;
            busy_q          <= 1'b0;
            dp_enable_q     <= 1'b0;
            done_q          <= 1'b0;
            retired_q       <= '0;
            dp_load_store_q <= 1'b0;
            dp_rw_q         <= 5'd0;
            dp_ra_q         <= 5'd0;
            dp_rb_q         <= 5'd0;
            dp_data_in_q    <= '0;
        end else begin
            instr_ready_q   <= instr_ready_d;
            busy_q          <= busy_d;
            dp_enable_q     <= dp_enable_d;
            done_q          <= done_d;
            retired_q       <= retired_d;
            dp_load_store_q <= dp_load_store_d;
            dp_rw_q         <= dp_rw_d;
            dp_ra_q         <= dp_ra_d;
            dp_rb_q         <= dp_rb_d;
            dp_data_in_q    <= dp_data_in_d;
        end
    end

    assign instr_ready   = instr_ready_q;
    assign busy          = busy_q;
    assign dp_enable     = dp_enable_q;
    assign done          = done_q;
    assign retired       = retired_q;
    assign dp_load_store = dp_load_store_q;
    assign dp_rw         = dp_rw_q;
    assign dp_ra         = dp_ra_q;
    assign dp_rb         = dp_rb_q;
    assign dp_dataIn     = dp_data_in_q;

endmodule

// File: tb/tb_ls_sequencer.sv
// Testbench for ls_sequencer: table-driven single-instruction vectors on a
// MEM_LAT=1 instance, plus hand-written reset-abort and continuous-valid
// handshake / counter-wrap sequences on a MEM_LAT=3, CNT_W=2 instance.
module tb_ls_sequencer;

    logic        clk;
    logic        reset;

    // instance A: MEM_LAT=1, CNT_W=16
    logic [31:0] instr_a;
    logic        valid_a;
    logic        ready_a, en_a, ls_a, busy_a, done_a;
    logic [4:0]  ra_a, rb_a, rw_a;
    logic [63:0] data_a;
    logic [15:0] retired_a;

    // instance B: MEM_LAT=3, CNT_W=2
    logic [31:0] instr_b;
    logic        valid_b;
    logic        ready_b, en_b, ls_b, busy_b, done_b;
    logic [4:0]  ra_b, rb_b, rw_b;
    logic [63:0] data_b;
    logic [1:0]  retired_b;

    ls_sequencer #(.BITS(63), .MEM_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .instr(instr_a), .instr_valid(valid_a),
        .instr_ready(ready_a), .dp_enable(en_a), .dp_load_store(ls_a),
        .dp_ra(ra_a), .dp_rb(rb_a), .dp_rw(rw_a), .dp_dataIn(data_a),
        .busy(busy_a), .done(done_a), .retired(retired_a)
    );

    ls_sequencer #(.BITS(63), .MEM_LAT(3), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .instr(instr_b), .instr_valid(valid_b),
        .instr_ready(ready_b), .dp_enable(en_b), .dp_load_store(ls_b),
        .dp_ra(ra_b), .dp_rb(rb_b), .dp_rw(rw_b), .dp_dataIn(data_b),
        .busy(busy_b), .done(done_b), .retired(retired_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitors
    int cyc      = 0;
    int en_cnt_a = 0;
    int done_cnt_a = 0;
    int en_viol  = 0;
    logic en_prev_a = 1'b0;
    logic en_prev_b = 1'b0;
    int ret_n    = 0;
    logic [1:0] ret_log [0:7];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        en_prev_a <= en_a;
        en_prev_b <= en_b;
        if (en_a) en_cnt_a <= en_cnt_a + 1;
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if ((en_a && en_prev_a) || (en_b && en_prev_b)) en_viol <= en_viol + 1;
        if (done_b && ret_n < 8) begin
            ret_log[ret_n] <= retired_b;
            ret_n <= ret_n + 1;
        end
    end

    typedef struct {
        logic [31:0] instr;
        logic        ls;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rw;
        logic [63:0] data;
    } vec_t;

    vec_t vecs [0:4];
    logic [31:0] hs_instr [0:4];
    int acc_cyc [0:4];
    logic [1:0] exp_ret [0:4];

    initial begin
        // store r3 -> [r4 + 0x10 + 1]
        vecs[0] = '{{1'b0, 5'd0,  5'd3,  5'd4,  16'h0010}, 1'b0, 5'd3,  5'd4,  5'd0,  64'h0000_0000_0000_0010};
        // load back into r7
        vecs[1] = '{{1'b1, 5'd7,  5'd0,  5'd4,  16'h0010}, 1'b1, 5'd0,  5'd4,  5'd7,  64'h0000_0000_0000_0010};
        // store with negative immediate
        vecs[2] = '{{1'b0, 5'd0,  5'd5,  5'd4,  16'hFFFF}, 1'b0, 5'd5,  5'd4,  5'd0,  64'hFFFF_FFFF_FFFF_FFFF};
        // load to r0, most negative immediate
        vecs[3] = '{{1'b1, 5'd0,  5'd31, 5'd31, 16'h8000}, 1'b1, 5'd31, 5'd31, 5'd0,  64'hFFFF_FFFF_FFFF_8000};
        // load to r31, most positive immediate
        vecs[4] = '{{1'b1, 5'd31, 5'd1,  5'd2,  16'h7FFF}, 1'b1, 5'd1,  5'd2,  5'd31, 64'h0000_0000_0000_7FFF};
        for (int k = 0; k < 5; k++) begin
            hs_instr[k] = {k[0], 5'(k + 1), 5'(k + 2), 5'(k + 3), 16'(k * 16'h0101)};
        end
        exp_ret[0] = 2'd1; exp_ret[1] = 2'd2; exp_ret[2] = 2'd3;
        exp_ret[3] = 2'd0; exp_ret[4] = 2'd1;

        reset = 1'b1; instr_a = 32'd0; valid_a = 1'b0; instr_b = 32'd0; valid_b = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready_a, 1); chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);   chk("rst_en", en_a, 0);
        chk("rst_ls", ls_a, 0);       chk("rst_ra", ra_a, 0);
        chk("rst_rb", rb_a, 0);       chk("rst_rw", rw_a, 0);
        chk("rst_data", data_a, 0);   chk("rst_retired", retired_a, 0);

        // reset mid-flight: accept a load, then reset during ADDR
        instr_a = {1'b1, 5'd9, 5'd2, 5'd3, 16'h1234}; valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0;
        chk("abort_busy_addr", busy_a, 1);
        chk("abort_ready_addr", ready_a, 0);
        chk("abort_rw_latched", rw_a, 9);
        reset = 1'b1;
        #1;
        chk("abort_ready_now", ready_a, 1);
        chk("abort_busy_now", busy_a, 0);
        chk("abort_rw_cleared", rw_a, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_enable", en_cnt_a, 0);
        chk("abort_no_done", done_cnt_a, 0);
        chk("abort_retired", retired_a, 0);

        // table-driven single instructions on instance A
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            instr_a = vecs[i].instr; valid_a = 1'b1;
            chk("v_ready_idle", ready_a, 1);
            @(posedge clk);
            @(negedge clk);                       // cycle 1: ADDR
            valid_a = 1'b0; instr_a = ~vecs[i].instr;
            chk("v_c1_busy", busy_a, 1);  chk("v_c1_ready", ready_a, 0);
            chk("v_c1_en", en_a, 0);      chk("v_c1_done", done_a, 0);
            @(negedge clk);                       // cycle 2: WRITE
            chk("v_c2_en", en_a, 1);      chk("v_c2_busy", busy_a, 1);
            chk("v_c2_ls", ls_a, vecs[i].ls);
            chk("v_c2_ra", ra_a, vecs[i].ra);
            chk("v_c2_rb", rb_a, vecs[i].rb);
            chk("v_c2_rw", rw_a, vecs[i].rw);
            chk("v_c2_data", data_a, vecs[i].data);
            @(negedge clk);                       // cycle 3: DONE
            chk("v_c3_done", done_a, 1);  chk("v_c3_en", en_a, 0);
            chk("v_c3_busy", busy_a, 0);
            chk("v_c3_retired", retired_a, 64'(i + 1));
            @(negedge clk);                       // cycle 4: IDLE, fields held
            chk("v_c4_ready", ready_a, 1); chk("v_c4_done", done_a, 0);
            chk("v_c4_ra_held", ra_a, vecs[i].ra);
            chk("v_c4_data_held", data_a, vecs[i].data);
        end
        chk("a_enable_pulses", en_cnt_a, 5);
        chk("a_done_pulses", done_cnt_a, 5);

        // continuous valid on instance B: spacing, ready low time, counter wrap
        @(negedge clk);
        valid_b = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int t;
            instr_b = hs_instr[k];
            t = 0;
            while (!ready_b && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (k > 0) chk("hs_ready_low_cycles", t, 5);
            chk("hs_ready", ready_b, 1);
            acc_cyc[k] = cyc;
            @(posedge clk);
            @(negedge clk);
            chk("hs_rw_latched", rw_b, 64'(k + 1));
        end
        valid_b = 1'b0;
        for (int t = 0; t < 20 && ret_n < 5; t++) @(negedge clk);
        chk("hs_done_count", ret_n, 5);
        for (int k = 1; k < 5; k++) chk("hs_spacing", acc_cyc[k] - acc_cyc[k-1], 6);
        for (int k = 0; k < 5; k++) chk("wrap_retired", ret_log[k], exp_ret[k]);
        chk("b_retired_final", retired_b, 1);
        chk("enable_never_consecutive", en_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
